// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths and arbiter state for regfile_wb_arbiter
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int REG_CNT = 32;
  localparam int ADDR_W = $clog2(REG_CNT);
  typedef enum logic {LAST_A, LAST_B} arb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: one requester's valid/ready write-request channel
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic              valid;
  logic [ADDR_W-1:0] wreg;
  logic [DATA_W-1:0] data;
  logic              ready;
  modport master (output valid, wreg, data, input ready);
  modport slave  (input valid, wreg, data, output ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant; ties go to the side not granted last
module rr_arb2 import regfile_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_a_i,
  input  logic valid_b_i,
  output logic grant_a_o,
  output logic grant_b_o
);
  arb_state_e state_q;
  always_comb begin
    grant_a_o = rst_n && valid_a_i && (!valid_b_i || state_q == LAST_B);
    grant_b_o = rst_n && valid_b_i && !grant_a_o;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LAST_B;
    else if (grant_a_o) state_q <= LAST_A;
    else if (grant_b_o) state_q <= LAST_B;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two write requesters onto a register-file write port with a pending-write scoreboard.
// Optional RF_ZERO_REG_EN makes register 0 a hardwired zero.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int REG_CNT = regfile_pkg::REG_CNT,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave req_a,
  regfile_wb_arbiter_if.slave req_b,
  input  logic                resv_valid_i,
  input  logic [ADDR_W-1:0]   resv_reg_i,
  input  logic [ADDR_W-1:0]   read_reg1_i,
  input  logic [ADDR_W-1:0]   read_reg2_i,
  output logic                busy1_o,
  output logic                busy2_o,
  output logic                reg_write_o,
  output logic [ADDR_W-1:0]   write_reg_no_o,
  output logic [DATA_W-1:0]   write_data_o,
  output logic [REG_CNT-1:0]  pending_mask_o,
  output logic                err_sticky_o
);
  logic               gnt_a, gnt_b, xfer, zero_hit, resv_en;
  logic [ADDR_W-1:0]  sel_reg, wreg_q;
  logic [DATA_W-1:0]  sel_data, wdata_q;
  logic [REG_CNT-1:0] pending_q, pending_d;
  logic               err_q, err_d, rw_q, rw_d;
  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_a_i (req_a.valid),
    .valid_b_i (req_b.valid),
    .grant_a_o (gnt_a),
    .grant_b_o (gnt_b)
  );
  assign req_a.ready = gnt_a;
  assign req_b.ready = gnt_b;
  always_comb begin
    xfer = gnt_a || gnt_b;
    sel_reg = gnt_a ? req_a.wreg : req_b.wreg;
    sel_data = gnt_a ? req_a.data : req_b.data;
`ifdef RF_ZERO_REG_EN
    zero_hit = xfer && sel_reg == '0;
    resv_en = resv_valid_i && resv_reg_i != '0;
`else
    zero_hit = 1'b0;
    resv_en = resv_valid_i;
`endif
    rw_d = xfer && !zero_hit;
    err_d = err_q || (rw_d && !pending_q[sel_reg]);
    // set applied after clear so a same-cycle reservation wins
    pending_d = (pending_q & ~(xfer ? REG_CNT'(1) << sel_reg : '0))
              | (resv_en ? REG_CNT'(1) << resv_reg_i : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q <= 1'b0;
      rw_q <= 1'b0;
      wreg_q <= '0;
      wdata_q <= '0;
    end else begin
      pending_q <= pending_d;
      err_q <= err_d;
      rw_q <= rw_d;
      if (xfer) begin
        wreg_q <= sel_reg;
        wdata_q <= sel_data;
      end
    end
  end
  assign busy1_o = pending_q[read_reg1_i];
  assign busy2_o = pending_q[read_reg2_i];
  assign reg_write_o = rw_q;
  assign write_reg_no_o = wreg_q;
  assign write_data_o = wdata_q;
  assign pending_mask_o = pending_q;
  assign err_sticky_o = err_q;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32: write-data width.
- REQ-002 The block SHALL have parameter REG_CNT, default 32: register count. ADDR_W = clog2(REG_CNT) = 5.
- REQ-003 Ports SHALL be as follows; the block has one clock, and reset is asynchronous and active-low:
  - Clock  in  1  sole clock, rising edge.
  - Reset  in  1  asynchronous, active-low.
  - ReqValidA  in  1  requester A write request.
  - ReqRegA  in  ADDR_W  requester A destination register.
  - ReqDataA  in  DATA_W  requester A write data.
  - ReqReadyA  out  1  requester A accepted this cycle.
  - ReqValidB, ReqRegB, ReqDataB, ReqReadyB  as A, for requester B.
  - ResvValid  in  1  reserve (mark pending) a register.
  - ResvReg  in  ADDR_W  register to reserve.
  - ReadReg1, ReadReg2  in  ADDR_W  read-port addresses to check.
  - Busy1, Busy2  out  1  addressed register has a pending write.
  - RegWrite  out  1  register-file write enable.
  - WriteRegNo  out  ADDR_W  register-file write address.
  - WriteData  out  DATA_W  register-file write data.
  - PendingMask  out  REG_CNT  scoreboard state.
  - ErrSticky  out  1  a write hit a non-pending register.

Function
- REQ-004 A transfer SHALL occur on a cycle where ReqValidX=1 and ReqReadyX=1; at most one Ready is high per cycle.
- REQ-005 Ready SHALL be combinational from both Valids and the arbiter state. Only one Valid: that requester is granted. Both Valid: the requester not granted last is granted.
- REQ-006 The arbiter SHALL be a two-state FSM, LAST_A and LAST_B. It moves to LAST_A or LAST_B on each A or B transfer, respectively, and holds otherwise.
- REQ-007 Requesters SHALL hold Valid, Reg and Data stable until Ready; the block does not buffer an ungranted request.
- REQ-008 On a transfer, RegWrite, WriteRegNo and WriteData SHALL be registered with the granted payload.
  - Latency: 1 cycle from the handshake edge.
  - RegWrite=0 on cycles with no transfer; WriteRegNo and WriteData hold.
- REQ-009 Throughput SHALL be one write per cycle; back-to-back transfers alternate between requesters while both are valid.
- REQ-010 ResvValid=1 SHALL set PendingMask[ResvReg] at the clock edge.
- REQ-011 A transfer to register r SHALL clear PendingMask[r] at the same edge.
- REQ-012 A simultaneous reservation and write to the same register SHALL leave the bit set (reservation wins).
- REQ-013 Reserving an already-pending register SHALL leave it set; there is no counting.
- REQ-014 A transfer to a register whose pending bit is 0 SHALL still be written, and SHALL set ErrSticky on the next edge.
- REQ-015 Busy1 = PendingMask[ReadReg1] and Busy2 = PendingMask[ReadReg2], both combinational. A bit clearing at edge t shows Busy=0 from cycle t onward.

Reset
- REQ-016 While Reset=0, all of the following SHALL be held:
  - RegWrite=0, WriteRegNo=0, WriteData=0.
  - PendingMask=0, ErrSticky=0.
  - FSM=LAST_B, so A wins the first tie.
- REQ-017 Reset asserted mid-operation SHALL drop any in-flight registered write (RegWrite forced 0) and all pending bits. Requesters re-issue after release.
- REQ-018 ReqReady SHALL be 0 while Reset=0.

Configuration
- REQ-019 With macro RF_ZERO_REG_EN defined, register 0 SHALL behave as hardwired zero:
  - Writes to register 0 handshake normally but produce RegWrite=0.
  - Reservations of register 0 are ignored.
  - PendingMask[0] stays 0, and Busy for address 0 is always 0.
  - Writes to register 0 never set ErrSticky.
- REQ-020 Without RF_ZERO_REG_EN, register 0 SHALL be treated like every other register.

Structure
- REQ-021 Package regfile_pkg SHALL hold DATA_W, REG_CNT, ADDR_W and the arbiter state enum (LAST_A, LAST_B).
- REQ-022 The two-requester round-robin grant logic SHALL be sub-module rr_arb2: inputs two valids, outputs two grants, state internal; the scoreboard stays in the top level.

Verification
- REQ-023 Reset release, then ResvValid with reg 5; A writes reg 5 with 0xDEADBEEF -> next cycle RegWrite=1, WriteRegNo=5, WriteData=0xDEADBEEF, PendingMask[5]=0, ErrSticky=0.
- REQ-024 Both valid for 4 cycles, A to reg 1 and B to reg 2, re-presenting after each accept -> grant order A,B,A,B; RegWrite=1 every cycle.
- REQ-025 Reserve reg 7 while B writes reg 7 in the same cycle -> PendingMask[7] stays 1, and Busy1=1 with ReadReg1=7.
- REQ-026 A writes reg 9 with no reservation -> write issued and ErrSticky=1 until reset.
- REQ-027 RF_ZERO_REG_EN defined: reserve reg 0, then A writes reg 0 with 0x1234 -> ReqReadyA=1, RegWrite=0, PendingMask=0, ErrSticky=0.
- REQ-028 Assert Reset on the cycle after a handshake -> RegWrite=0, PendingMask=0, FSM=LAST_B; after release a tie grants A.
